// File: rtl/legv8_encoder.sv
// LEGv8 instruction encoder and program loader: packs symbolic requests into
// 32-bit machine words, buffers them in a FIFO and streams them into instruction
// memory. Optional immediate range checking is enabled by ENC_RANGE_CHECK_EN.
module legv8_encoder #(
    parameter int                DEPTH     = 4,
    parameter int                ADDR_W    = 6,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic [3:0]                 req_mnem,
    input  logic [4:0]                 req_rd,
    input  logic [4:0]                 req_rn,
    input  logic [4:0]                 req_rm,
    input  logic [25:0]                req_imm,
    input  logic                       imem_busy,
    output logic                       imem_we,
    output logic [ADDR_W-1:0]          imem_addr,
    output logic [31:0]                imem_wdata,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE  = PTR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

    typedef enum logic [3:0] {
        MN_LDUR = 4'd0,
        MN_STUR = 4'd1,
        MN_CBZ  = 4'd2,
        MN_ADD  = 4'd3,
        MN_SUB  = 4'd4,
        MN_AND  = 4'd5,
        MN_ORR  = 4'd6,
        MN_B    = 4'd7,
        MN_BR   = 4'd8,
        MN_ADDI = 4'd9,
        MN_ANDI = 4'd10,
        MN_ORRI = 4'd11,
        MN_SUBI = 4'd12,
        MN_MOVZ = 4'd13
    } mnem_e;

    localparam logic [10:0] OP_ADD  = 11'b10001011000;
    localparam logic [10:0] OP_SUB  = 11'b11001011000;
    localparam logic [10:0] OP_AND  = 11'b10001010000;
    localparam logic [10:0] OP_ORR  = 11'b10101010000;
    localparam logic [9:0]  OP_ADDI = 10'b1001000100;
    localparam logic [9:0]  OP_ANDI = 10'b1001001000;
    localparam logic [9:0]  OP_ORRI = 10'b1011001000;
    localparam logic [9:0]  OP_SUBI = 10'b1101000100;
    localparam logic [10:0] OP_LDUR = 11'b11111000010;
    localparam logic [10:0] OP_STUR = 11'b11111000000;
    localparam logic [7:0]  OP_CBZ  = 8'b10110100;
    localparam logic [5:0]  OP_B    = 6'b000101;
    localparam logic [10:0] OP_BR   = 11'b11010110000;
    localparam logic [8:0]  OP_MOVZ = 9'b110100101;

    mnem_e             mnem;
    logic [31:0]       enc_word;
    logic              mnem_ok;
    logic              imm_fits;
    logic              fit_i;
    logic              fit_d;
    logic              fit_cb;
    logic              fit_iw;

    logic              accept;
    logic              push;
    logic              pop;

    logic [31:0]       mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              err_q, err_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;
    logic [ADDR_W-1:0] next_addr_q, next_addr_d;

    assign mnem = mnem_e'(req_mnem);

    // Immediate fit rules; without range checking every immediate is truncated.
`ifdef ENC_RANGE_CHECK_EN
    assign fit_i  = (req_imm[25:12] == '0);
    assign fit_d  = (&req_imm[25:8]) | ~(|req_imm[25:8]);
    assign fit_cb = (&req_imm[25:18]) | ~(|req_imm[25:18]);
    assign fit_iw = (req_imm[25:18] == '0);
`else
    assign fit_i  = 1'b1;
    assign fit_d  = 1'b1;
    assign fit_cb = 1'b1;
    assign fit_iw = 1'b1;
`endif

    always_comb begin
        enc_word = '0;
        mnem_ok  = 1'b1;
        imm_fits = 1'b1;
        case (mnem)
            MN_ADD:  enc_word = {OP_ADD, req_rm, 6'd0, req_rn, req_rd};
            MN_SUB:  enc_word = {OP_SUB, req_rm, 6'd0, req_rn, req_rd};
            MN_AND:  enc_word = {OP_AND, req_rm, 6'd0, req_rn, req_rd};
            MN_ORR:  enc_word = {OP_ORR, req_rm, 6'd0, req_rn, req_rd};
            MN_ADDI: begin
                enc_word = {OP_ADDI, req_imm[11:0], req_rn, req_rd};
                imm_fits = fit_i;
            end
            MN_ANDI: begin
                enc_word = {OP_ANDI, req_imm[11:0], req_rn, req_rd};
                imm_fits = fit_i;
            end
            MN_ORRI: begin
                enc_word = {OP_ORRI, req_imm[11:0], req_rn, req_rd};
                imm_fits = fit_i;
            end
            MN_SUBI: begin
                enc_word = {OP_SUBI, req_imm[11:0], req_rn, req_rd};
                imm_fits = fit_i;
            end
            MN_LDUR: begin
                enc_word = {OP_LDUR, req_imm[8:0], 2'b00, req_rn, req_rd};
                imm_fits = fit_d;
            end
            MN_STUR: begin
                enc_word = {OP_STUR, req_imm[8:0], 2'b00, req_rn, req_rd};
                imm_fits = fit_d;
            end
            MN_CBZ: begin
                enc_word = {OP_CBZ, req_imm[18:0], req_rd};
                imm_fits = fit_cb;
            end
            MN_B:    enc_word = {OP_B, req_imm[25:0]};
            MN_BR:   enc_word = {OP_BR, 5'b11111, 6'd0, req_rn, 5'd0};
            MN_MOVZ: begin
                enc_word = {OP_MOVZ, req_imm[17:16], req_imm[15:0], req_rd};
                imm_fits = fit_iw;
            end
            default: mnem_ok = 1'b0;
        endcase
    end

    // Invalid or out-of-range requests still complete the handshake but are dropped.
    assign req_ready = (count_q != CNT_FULL);
    assign accept    = req_valid && req_ready;
    assign push      = accept && mnem_ok && imm_fits;
    assign pop       = (count_q != '0) && !imem_busy;

    always_comb begin
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_d        = err_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        next_addr_d  = next_addr_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_ONE;
            imem_we_d    = 1'b1;
            imem_addr_d  = next_addr_q;
            imem_wdata_d = mem_q[rd_ptr_q];
            next_addr_d  = next_addr_q + ADDR_ONE;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
        if (accept && !(mnem_ok && imm_fits)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= enc_word;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= BASE_ADDR;
            imem_wdata_q <= '0;
            next_addr_q  <= BASE_ADDR;
        end else begin
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            next_addr_q  <= next_addr_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign count      = count_q;
    assign err        = err_q;

endmodule

// File: tb/tb_legv8_encoder.sv
// Directed scoreboard bench for legv8_encoder: expected words are queued at
// request time and checked, with their addresses, as the memory writes appear.
module tb_legv8_encoder;

    localparam int              DEPTH     = 4;
    localparam int              ADDR_W    = 6;
    localparam logic [ADDR_W-1:0] BASE_ADDR = '0;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [3:0]        req_mnem = '0;
    logic [4:0]        req_rd = '0;
    logic [4:0]        req_rn = '0;
    logic [4:0]        req_rm = '0;
    logic [25:0]       req_imm = '0;
    logic              imem_busy = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_wdata;
    logic [$clog2(DEPTH):0] count;
    logic              err;

    logic [31:0]       exp_q[$];
    logic [ADDR_W-1:0] exp_addr = BASE_ADDR;
    int                tests_run = 0;
    int                tests_failed = 0;

    legv8_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(BASE_ADDR)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mnem   (req_mnem),
        .req_rd     (req_rd),
        .req_rn     (req_rn),
        .req_rm     (req_rm),
        .req_imm    (req_imm),
        .imem_busy  (imem_busy),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_wdata (imem_wdata),
        .count      (count),
        .err        (err)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Scoreboard side: every write must match the oldest queued word and the next address.
    always @(negedge clk) begin
        if (reset) begin
            exp_addr = BASE_ADDR;
        end else if (imem_we) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                tests_failed++;
                $error("[TB] FAIL unexpected_write: observed data 0x%08h addr %0d, expected no write",
                       imem_wdata, imem_addr);
            end else begin
                check_output("wdata", imem_wdata, exp_q.pop_front());
                check_output("waddr", 32'(imem_addr), 32'(exp_addr));
            end
            exp_addr = exp_addr + 1'b1;
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted the request.
    task automatic apply_stimulus(input logic [3:0] mnem, input logic [4:0] rd, input logic [4:0] rn,
                                  input logic [4:0] rm, input logic [25:0] imm);
        bit done;
        done      = 1'b0;
        req_valid = 1'b1;
        req_mnem  = mnem;
        req_rd    = rd;
        req_rn    = rn;
        req_rm    = rm;
        req_imm   = imm;
        for (int i = 0; i < 40 && !done; i++) begin
            if (req_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        if (!done) begin
            tests_run++;
            tests_failed++;
            $error("[TB] FAIL accept_timeout: observed req_ready=0 for 40 cycles, expected acceptance");
        end
    endtask

    task automatic wait_drain();
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        check_output("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_we",    32'(imem_we),    32'd0);
        check_output("rst_wdata", imem_wdata,      32'd0);
        check_output("rst_addr",  32'(imem_addr),  32'(BASE_ADDR));
        check_output("rst_count", 32'(count),      32'd0);
        check_output("rst_err",   32'(err),        32'd0);
        check_output("rst_ready", 32'(req_ready),  32'd1);
        reset = 1'b0;
        @(posedge clk);
        #1;

        // ADD rd=3 rn=1 rm=2, write one cycle after acceptance
        exp_q.push_back(32'h8B020023);
        apply_stimulus(4'd3, 5'd3, 5'd1, 5'd2, 26'd0);
        @(posedge clk);
        #1;
        check_output("lat_we",   32'(imem_we),   32'd1);
        check_output("lat_addr", 32'(imem_addr), 32'(BASE_ADDR));
        check_output("lat_data", imem_wdata,     32'h8B020023);
        wait_drain();

        // LDUR then CBZ with a negative offset, back to back
        exp_q.push_back(32'hF84402C9);
        apply_stimulus(4'd0, 5'd9, 5'd22, 5'd0, 26'd64);
        exp_q.push_back(32'hB4FFFFC5);
        apply_stimulus(4'd2, 5'd5, 5'd0, 5'd0, 26'h3FFFFFE);
        wait_drain();

        // B, BR, MOVZ with hw=1
        exp_q.push_back(32'h14000003);
        apply_stimulus(4'd7, 5'd0, 5'd0, 5'd0, 26'd3);
        exp_q.push_back(32'hD61F03C0);
        apply_stimulus(4'd8, 5'd0, 5'd30, 5'd0, 26'd0);
        exp_q.push_back(32'hD2B7DDE1);
        apply_stimulus(4'd13, 5'd1, 5'd0, 5'd0, 26'h001BEEF);
        wait_drain();

        // SUB with all-ones registers, ORRI max imm12, STUR most-negative offset
        exp_q.push_back(32'hCB1F03FF);
        apply_stimulus(4'd4, 5'd31, 5'd31, 5'd31, 26'd0);
        exp_q.push_back(32'hB23FFC82);
        apply_stimulus(4'd11, 5'd2, 5'd4, 5'd0, 26'hFFF);
        exp_q.push_back(32'hF8100041);
        apply_stimulus(4'd1, 5'd1, 5'd2, 5'd0, 26'h3FFFF00);
        wait_drain();

        // Backpressure: fill to DEPTH while busy, fifth request stalls
        imem_busy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            exp_q.push_back(32'h91000000 | (32'(k) << 10) | 32'(k));
            apply_stimulus(4'd9, 5'(k), 5'd0, 5'd0, 26'(k));
        end
        check_output("full_count", 32'(count),     32'd4);
        check_output("full_ready", 32'(req_ready), 32'd0);
        check_output("busy_we",    32'(imem_we),   32'd0);
        exp_q.push_back(32'h91001405);
        req_mnem  = 4'd9;
        req_rd    = 5'd5;
        req_rn    = 5'd0;
        req_rm    = 5'd0;
        req_imm   = 26'd5;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        check_output("full_hold", 32'(count), 32'd4);
        imem_busy = 1'b0;
        @(posedge clk);
        #1;
        check_output("burst_we0", 32'(imem_we), 32'd1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        check_output("burst_we1", 32'(imem_we), 32'd1);
        for (int k = 2; k < 5; k++) begin
            @(posedge clk);
            #1;
            check_output($sformatf("burst_we%0d", k), 32'(imem_we), 32'd1);
        end
        @(posedge clk);
        #1;
        check_output("burst_end_we", 32'(imem_we), 32'd0);
        check_output("burst_count",  32'(count),   32'd0);

        // Invalid mnemonic sets err; oversize ADDI immediate depends on range checking
        check_output("err_clear", 32'(err), 32'd0);
        apply_stimulus(4'd15, 5'd0, 5'd0, 5'd0, 26'd0);
        check_output("err_invalid", 32'(err),   32'd1);
        check_output("inv_count",   32'(count), 32'd0);
`ifndef ENC_RANGE_CHECK_EN
        exp_q.push_back(32'h91000000);
`endif
        apply_stimulus(4'd9, 5'd0, 5'd0, 5'd0, 26'd4096);
`ifdef ENC_RANGE_CHECK_EN
        check_output("range_count", 32'(count), 32'd0);
`endif
        wait_drain();
        check_output("err_sticky", 32'(err), 32'd1);

        // Reset with three words buffered
        imem_busy = 1'b1;
        for (int k = 0; k < 3; k++) begin
            exp_q.push_back(32'h8B020023);
            apply_stimulus(4'd3, 5'd3, 5'd1, 5'd2, 26'd0);
        end
        check_output("pre_rst_count", 32'(count), 32'd3);
        reset = 1'b1;
        #2;
        check_output("mid_rst_count", 32'(count),     32'd0);
        check_output("mid_rst_we",    32'(imem_we),   32'd0);
        check_output("mid_rst_err",   32'(err),       32'd0);
        check_output("mid_rst_ready", 32'(req_ready), 32'd1);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset     = 1'b0;
        imem_busy = 1'b0;
        exp_q.push_back(32'h8A0400A3);
        apply_stimulus(4'd5, 5'd3, 5'd5, 5'd4, 26'd0);
        @(posedge clk);
        #1;
        check_output("post_rst_we",   32'(imem_we),   32'd1);
        check_output("post_rst_addr", 32'(imem_addr), 32'(BASE_ADDR));
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
